logic_basic_gray_counter: RTL and testbench
===========================================

LOGIC_BASIC_GRAY_COUNTER -- requirements
Module: logic_basic_gray_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; SHALL be >= 2.
REQ-002 Parameter RESET_VALUE, default 0: binary value loaded on reset; SHALL be < 2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at bounds, 1 = hold at bounds.
REQ-004 aclk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 srst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  count step request for this cycle.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  load request for this cycle.
REQ-009 load_value  input  WIDTH  binary value to load.
REQ-010 o_binary  output  WIDTH  registered binary count.
REQ-011 o_gray  output  WIDTH  registered Gray code of o_binary.
REQ-012 o_bound  output  1  registered one-cycle pulse: a step crossed or hit a bound.

Function
REQ-013 Next-state priority SHALL be srst > load > enable > hold.
REQ-014 load=1: o_binary SHALL equal load_value one cycle later, regardless of enable/up; o_bound SHALL be 0.
REQ-015 enable=1, load=0, up=1, o_binary < 2**WIDTH-1: o_binary SHALL increment by 1.
REQ-016 enable=1, load=0, up=0, o_binary > 0: o_binary SHALL decrement by 1.
REQ-017 Up step at 2**WIDTH-1: SATURATE=0 -> o_binary becomes 0; SATURATE=1 -> o_binary holds; o_bound=1 next cycle in both cases.
REQ-018 Down step at 0: SATURATE=0 -> o_binary becomes 2**WIDTH-1; SATURATE=1 -> o_binary holds; o_bound=1 next cycle in both cases.
REQ-019 o_bound SHALL be 0 in every cycle not following a REQ-017/018 event.
REQ-020 enable=0, load=0: o_binary, o_gray SHALL hold; o_bound=0.
REQ-021 o_gray SHALL equal o_binary XOR (o_binary >> 1) in every cycle, both registered; no combinational path from any input to any output.
REQ-022 Latency from input sampled at edge N to output change SHALL be exactly 1 cycle.
REQ-023 Between consecutive cycles where a single count step occurs (including wrap, SATURATE=0), o_gray SHALL differ in exactly one bit; hold cycles differ in zero bits.
REQ-024 Arithmetic SHALL be modulo 2**WIDTH; no internal state wider than WIDTH besides o_bound.

Reset
REQ-025 srst=1 sampled at an edge: o_binary = RESET_VALUE, o_gray = Gray(RESET_VALUE), o_bound = 0 after that edge, overriding load and enable.
REQ-026 srst asserted mid-count or in the cycle of a bound event SHALL suppress o_bound and all counting; counting resumes on the first edge with srst=0.
REQ-027 Output values before the first srst edge are undefined; bench SHALL not check them.

Verification
REQ-028 WIDTH=4, SATURATE=0, reset, enable=1 up=1 for 17 cycles -> o_binary 0..15,0,1; o_gray 0,1,3,2,6,...,8,0,1; o_bound=1 only in cycle after 15->0.
REQ-029 WIDTH=4, SATURATE=1, load 14 then enable up=1 for 4 cycles -> o_binary 14,15,15,15,15; o_bound=1 on the last three held cycles, 0 on the 14->15 cycle.
REQ-030 WIDTH=4, SATURATE=0, load 1, enable up=0 for 3 cycles -> o_binary 0,15,14; o_gray 0,8,9; o_bound pulse only after 0->15.
REQ-031 load=1 load_value=9 with enable=1 up=1 same cycle -> o_binary=9, o_gray=13 next cycle, o_bound=0; then srst=1 with load=1 -> o_binary=RESET_VALUE.
REQ-032 WIDTH=8, random enable/up/load/srst for 10000 cycles against reference model -> exact match on all outputs; REQ-021 and REQ-023 checked every cycle.

Source files
------------

// File: rtl/logic_basic_gray_counter.sv
// -----------------------------------------------------------------------------
// logic_basic_gray_counter
//   Up/down binary counter with a registered Gray-code mirror and a one-cycle
//   bound pulse. Next-state priority: srst > load > enable > hold.
//
// Parameters
//   WIDTH        counter width in bits (>= 2)
//   RESET_VALUE  binary value loaded by srst (< 2**WIDTH)
//   SATURATE     0 = wrap at 0 / 2**WIDTH-1, 1 = hold at the bound
//
// Ports
//   aclk        clock, all state updates on the rising edge
//   srst        synchronous active-high reset
//   enable      request one count step this cycle
//   up          step direction, 1 = increment, 0 = decrement
//   load        load load_value this cycle (overrides enable)
//   load_value  binary value to load
//   o_binary    registered binary count
//   o_gray      registered Gray code of o_binary
//   o_bound     registered pulse: the previous step hit or crossed a bound
// -----------------------------------------------------------------------------
module logic_basic_gray_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0,
  parameter bit          SATURATE    = 1'b0
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] o_binary,
  output logic [WIDTH-1:0] o_gray,
  output logic             o_bound
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             bound_next;

  assign at_max = &o_binary;
  assign at_min = ~|o_binary;

  // Reset is handled in the register block; this computes load/step/hold.
  always_comb begin
    bin_next   = o_binary;
    bound_next = 1'b0;
    if (load) begin
      bin_next = load_value;
    end else if (enable) begin
      if (up) begin
        if (at_max) begin
          bound_next = 1'b1;
          bin_next   = SATURATE ? o_binary : '0;
        end else begin
          bin_next = o_binary + ONE;
        end
      end else begin
        if (at_min) begin
          bound_next = 1'b1;
          bin_next   = SATURATE ? o_binary : '1;
        end else begin
          bin_next = o_binary - ONE;
        end
      end
    end
  end

  // Gray is derived from the next binary value so both outputs are registered
  // in the same edge and always agree.
  assign gray_next = bin_next ^ (bin_next >> 1);

  always_ff @(posedge aclk) begin
    if (srst) begin
      o_binary <= RST_BIN;
      o_gray   <= RST_GRAY;
      o_bound  <= 1'b0;
    end else begin
      o_binary <= bin_next;
      o_gray   <= gray_next;
      o_bound  <= bound_next;
    end
  end

endmodule

// File: tb/tb_logic_basic_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_logic_basic_gray_counter
//   Three instances: a_ = WIDTH 4 wrap, b_ = WIDTH 4 saturate,
//   c_ = WIDTH 8 wrap with RESET_VALUE 200 (directed then pseudo-random
//   against a behavioural model).
// -----------------------------------------------------------------------------
module tb_logic_basic_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // instance a: WIDTH=4, SATURATE=0, RESET_VALUE=0
  logic       a_srst, a_en, a_up, a_load, a_bound;
  logic [3:0] a_lv, a_bin, a_gray;
  // instance b: WIDTH=4, SATURATE=1, RESET_VALUE=0
  logic       b_srst, b_en, b_up, b_load, b_bound;
  logic [3:0] b_lv, b_bin, b_gray;
  // instance c: WIDTH=8, SATURATE=0, RESET_VALUE=200
  logic       c_srst, c_en, c_up, c_load, c_bound;
  logic [7:0] c_lv, c_bin, c_gray;

  logic_basic_gray_counter #(.WIDTH(4), .RESET_VALUE(0), .SATURATE(1'b0)) u_a (
    .aclk(clk), .srst(a_srst), .enable(a_en), .up(a_up), .load(a_load),
    .load_value(a_lv), .o_binary(a_bin), .o_gray(a_gray), .o_bound(a_bound));

  logic_basic_gray_counter #(.WIDTH(4), .RESET_VALUE(0), .SATURATE(1'b1)) u_b (
    .aclk(clk), .srst(b_srst), .enable(b_en), .up(b_up), .load(b_load),
    .load_value(b_lv), .o_binary(b_bin), .o_gray(b_gray), .o_bound(b_bound));

  logic_basic_gray_counter #(.WIDTH(8), .RESET_VALUE(200), .SATURATE(1'b0)) u_c (
    .aclk(clk), .srst(c_srst), .enable(c_en), .up(c_up), .load(c_load),
    .load_value(c_lv), .o_binary(c_bin), .o_gray(c_gray), .o_bound(c_bound));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed Gray codes of 0..15.
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  initial begin
    logic [3:0] prev4;
    logic [7:0] prev8;
    int         m;
    int         mb;
    int         kind;   // 0 = load/reset, 1 = value-changing step, 2 = no change

    {a_srst, a_en, a_up, a_load, a_lv} = '0;
    {b_srst, b_en, b_up, b_load, b_lv} = '0;
    {c_srst, c_en, c_up, c_load, c_lv} = '0;
    a_srst = 1'b1; b_srst = 1'b1; c_srst = 1'b1;
    c_load = 1'b1; c_lv = 8'd17;   // reset must override load
    #2;
    tick();
    a_srst = 1'b0; b_srst = 1'b0; c_srst = 1'b0; c_load = 1'b0;

    chk("a_rst_bin",   a_bin,   0);
    chk("a_rst_gray",  a_gray,  0);
    chk("a_rst_bound", a_bound, 0);
    chk("c_rst_bin",   c_bin,   200);
    chk("c_rst_gray",  c_gray,  32'hAC);
    chk("c_rst_bound", c_bound, 0);

    // 17 up-steps on the wrapping 4-bit counter
    a_en = 1'b1; a_up = 1'b1;
    prev4 = a_gray;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("a_inc_bin",   a_bin,   k % 16);
      chk("a_inc_gray",  a_gray,  gtab[k % 16]);
      chk("a_inc_bound", a_bound, (k == 16) ? 1 : 0);
      chk("a_inc_1bit",  $countones(a_gray ^ prev4), 1);
      prev4 = a_gray;
    end

    // hold
    a_en = 1'b0;
    tick();
    chk("a_hold_bin",   a_bin,   1);
    chk("a_hold_gray",  a_gray,  1);
    chk("a_hold_bound", a_bound, 0);

    // load 1 then three down-steps: 0, 15 (wrap), 14
    a_load = 1'b1; a_lv = 4'd1;
    tick();
    chk("a_ld1_bin", a_bin, 1);
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b0;
    tick();
    chk("a_dec0_bin", a_bin, 0);  chk("a_dec0_gray", a_gray, 0); chk("a_dec0_bound", a_bound, 0);
    tick();
    chk("a_dec1_bin", a_bin, 15); chk("a_dec1_gray", a_gray, 8); chk("a_dec1_bound", a_bound, 1);
    tick();
    chk("a_dec2_bin", a_bin, 14); chk("a_dec2_gray", a_gray, 9); chk("a_dec2_bound", a_bound, 0);

    // load wins over enable; then reset wins over load
    a_load = 1'b1; a_lv = 4'd9; a_en = 1'b1; a_up = 1'b1;
    tick();
    chk("a_ld9_bin", a_bin, 9); chk("a_ld9_gray", a_gray, 13); chk("a_ld9_bound", a_bound, 0);
    a_srst = 1'b1; a_lv = 4'd5;
    tick();
    chk("a_rstld_bin", a_bin, 0); chk("a_rstld_gray", a_gray, 0);
    a_srst = 1'b0; a_load = 1'b0; a_en = 1'b0;

    // saturating counter: load 14, four up-steps
    b_load = 1'b1; b_lv = 4'd14;
    tick();
    chk("b_ld14_bin", b_bin, 14); chk("b_ld14_bound", b_bound, 0);
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("b_sat_bin",   b_bin,   15);
      chk("b_sat_gray",  b_gray,  8);
      chk("b_sat_bound", b_bound, (k == 1) ? 0 : 1);
    end
    b_en = 1'b0;
    tick();
    chk("b_sat_idle_bound", b_bound, 0);
    // saturate at 0 going down
    b_load = 1'b1; b_lv = 4'd0;
    tick();
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b0;
    tick();
    chk("b_satlo_bin", b_bin, 0); chk("b_satlo_bound", b_bound, 1);
    b_en = 1'b0;

    // reset in the cycle of a bound event suppresses the pulse
    c_load = 1'b1; c_lv = 8'd255;
    tick();
    c_load = 1'b0; c_en = 1'b1; c_up = 1'b1; c_srst = 1'b1;
    tick();
    chk("c_rstbnd_bin", c_bin, 200); chk("c_rstbnd_bound", c_bound, 0);
    c_srst = 1'b0;
    tick();
    chk("c_resume_bin", c_bin, 201); chk("c_resume_bound", c_bound, 0);

    // pseudo-random run against a behavioural model
    m = 201;
    prev8 = c_gray;
    for (int n = 0; n < 10000; n++) begin
      c_srst = ($urandom_range(49) == 0);
      c_load = ($urandom_range(19) == 0);
      c_en   = ($urandom_range(3) != 0);
      c_up   = $urandom_range(1);
      c_lv   = 8'($urandom_range(255));
      mb = 0;
      kind = 2;
      if (c_srst) begin
        m = 200; kind = 0;
      end else if (c_load) begin
        m = int'(c_lv); kind = 0;
      end else if (c_en) begin
        kind = 1;
        if (c_up) begin
          if (m == 255) begin m = 0; mb = 1; end else m = m + 1;
        end else begin
          if (m == 0) begin m = 255; mb = 1; end else m = m - 1;
        end
      end
      tick();
      chk("c_rnd_bin",   c_bin,   m);
      chk("c_rnd_gray",  c_gray,  m ^ (m >> 1));
      chk("c_rnd_bound", c_bound, mb);
      if (kind == 1) chk("c_rnd_1bit", $countones(c_gray ^ prev8), 1);
      if (kind == 2) chk("c_rnd_0bit", $countones(c_gray ^ prev8), 0);
      prev8 = c_gray;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
